// File: rtl/mil_line_transmitter_pkg.sv
// Shared MIL-STD-1553 word types, transmitter states and Manchester half-bit encoding.
// Imported by the line transmitter and its half-bit timer.
package mil_line_transmitter_pkg;

   typedef enum logic [1:0] {
      WCOMMAND = 2'd0,
      WSTATUS  = 2'd1,
      WDATA    = 2'd2,
      WERROR   = 2'd3
   } word_type_t;

   typedef struct packed {
      word_type_t  data_type;
      logic [15:0] data_word;
   } mil_data_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SYNC   = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_DONE   = 3'd5
   } tx_state_t;

   localparam logic [5:0] MIL_SYNC_HALFBITS = 6'd6;
   localparam logic [5:0] MIL_WORD_HALFBITS = 6'd40;
   localparam logic [5:0] MIL_DATA_END      = 6'd38;
   localparam logic [5:0] MIL_LAST_HALFBIT  = 6'd39;

   // Odd parity over the 16 data bits plus the parity bit; error words flip it on purpose.
   function automatic logic word_parity(input word_type_t wt, input logic [15:0] w);
      return (~^w) ^ (wt == WERROR);
   endfunction

   // Line level (1 = HIGH) of half-bit idx of a word; idx 0 is the first sync half-bit.
   function automatic logic half_level(input word_type_t wt, input logic [15:0] w,
                                       input logic [5:0] idx);
      logic       cmd_sync;
      logic [5:0] rel;
      logic [3:0] bit_pos;
      logic       lvl;
      cmd_sync = (wt == WCOMMAND) || (wt == WSTATUS);
      rel      = idx - MIL_SYNC_HALFBITS;
      bit_pos  = 4'd15 - rel[4:1];
      if (idx < 6'd3) begin
         lvl = cmd_sync;
      end else if (idx < MIL_SYNC_HALFBITS) begin
         lvl = ~cmd_sync;
      end else if (idx < MIL_DATA_END) begin
         lvl = w[bit_pos] ^ rel[0];
      end else begin
         lvl = word_parity(wt, w) ^ idx[0];
      end
      return lvl;
   endfunction

endpackage

// File: rtl/mil_line_transmitter_timer.sv
// Half-bit prescaler: strobes on the last clock of every half-bit while run is high.
// Held at zero whenever run is low so each word starts on a clean half-bit boundary.
module mil_line_transmitter_timer #(
   parameter int HALFBIT_CLKS = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic strobe
);

   localparam int CNT_W = (HALFBIT_CLKS > 2) ? $clog2(HALFBIT_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALFBIT_CLKS - 1);

   logic [CNT_W-1:0] cnt_r;

   // Prescaler counts 0..HALFBIT_CLKS-1 and wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (!run) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   assign strobe = run && (cnt_r == CNT_LAST);

endmodule

// File: rtl/mil_line_transmitter.sv
// Manchester II line transmitter for MIL-STD-1553 words: sync, 16 data bits, parity.
// Accepts one word per request handshake and pulses mil_done after the last half-bit.
module mil_line_transmitter
   import mil_line_transmitter_pkg::*;
#(
   parameter int HALFBIT_CLKS = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mil_request,
   input  logic [1:0]  mil_data_type,
   input  logic [15:0] mil_data_word,
   output logic        mil_done,
   output logic        lineP,
   output logic        lineN,
   output logic        lineEn,
   output logic        busy
);

   tx_state_t  state_r;
   mil_data_t  held_r;
   logic [5:0] idx_r;

   logic       run_s;
   logic       strobe_s;
   logic [5:0] idx_next_s;
   logic       level_next_s;
   tx_state_t  phase_next_s;

   mil_line_transmitter_timer #(
      .HALFBIT_CLKS (HALFBIT_CLKS)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (run_s),
      .strobe (strobe_s)
   );

   // Prescaler only runs while half-bits are on the line.
   always_comb begin
      run_s = 1'b0;
      case (state_r)
         ST_SYNC, ST_DATA, ST_PARITY: run_s = 1'b1;
         default:                     run_s = 1'b0;
      endcase
   end

   // Level and phase of the next half-bit; from LOAD the first level comes straight off the bus.
   always_comb begin
      idx_next_s = idx_r + 6'd1;
      if (state_r == ST_LOAD) begin
         level_next_s = half_level(word_type_t'(mil_data_type), mil_data_word, 6'd0);
      end else begin
         level_next_s = half_level(held_r.data_type, held_r.data_word, idx_next_s);
      end
      if (idx_next_s < MIL_SYNC_HALFBITS) begin
         phase_next_s = ST_SYNC;
      end else if (idx_next_s < MIL_DATA_END) begin
         phase_next_s = ST_DATA;
      end else begin
         phase_next_s = ST_PARITY;
      end
   end

   // Transmit FSM with registered line, enable, busy and done outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r            <= ST_IDLE;
         held_r.data_type   <= WCOMMAND;
         held_r.data_word   <= 16'h0000;
         idx_r              <= 6'd0;
         lineP              <= 1'b0;
         lineN              <= 1'b0;
         lineEn             <= 1'b0;
         mil_done           <= 1'b0;
         busy               <= 1'b0;
      end else begin
         mil_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               lineP  <= 1'b0;
               lineN  <= 1'b0;
               lineEn <= 1'b0;
               idx_r  <= 6'd0;
               if (mil_request) begin
                  state_r <= ST_LOAD;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            ST_LOAD: begin
               held_r.data_type <= word_type_t'(mil_data_type);
               held_r.data_word <= mil_data_word;
               idx_r            <= 6'd0;
               lineP            <= level_next_s;
               lineN            <= ~level_next_s;
               lineEn           <= 1'b1;
               state_r          <= ST_SYNC;
            end
            ST_SYNC, ST_DATA, ST_PARITY: begin
               if (strobe_s && (idx_r == MIL_LAST_HALFBIT)) begin
                  lineP    <= 1'b0;
                  lineN    <= 1'b0;
                  lineEn   <= 1'b0;
                  mil_done <= 1'b1;
                  state_r  <= ST_DONE;
               end else if (strobe_s) begin
                  idx_r   <= idx_next_s;
                  lineP   <= level_next_s;
                  lineN   <= ~level_next_s;
                  state_r <= phase_next_s;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               idx_r   <= 6'd0;
               state_r <= ST_IDLE;
            end
            default: begin
               lineP   <= 1'b0;
               lineN   <= 1'b0;
               lineEn  <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mil_line_transmitter.sv
// Directed bench for mil_line_transmitter at HALFBIT_CLKS=2 with hand-computed half-bit patterns.
// Pattern bit 39 is the first sync half-bit; 1 = HIGH (lineP=1, lineN=0).
module tb_mil_line_transmitter;
   import mil_line_transmitter_pkg::*;

   localparam int H = 2;

   logic        clk;
   logic        rst;
   logic        mil_request;
   logic [1:0]  mil_data_type;
   logic [15:0] mil_data_word;
   logic        mil_done;
   logic        lineP;
   logic        lineN;
   logic        lineEn;
   logic        busy;

   int total;
   int bad;

   mil_line_transmitter #(
      .HALFBIT_CLKS (H)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mil_request   (mil_request),
      .mil_data_type (mil_data_type),
      .mil_data_word (mil_data_word),
      .mil_done      (mil_done),
      .lineP         (lineP),
      .lineN         (lineN),
      .lineEn        (lineEn),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs packed as {lineP, lineN, lineEn, mil_done, busy}.
   function automatic logic [31:0] outs();
      return {27'd0, lineP, lineN, lineEn, mil_done, busy};
   endfunction

   // Sends one word starting in the current cycle (cycle 0) and checks it cycle by cycle.
   // A second request is pulsed in cycle pulse_cyc (with garbage data) when pulse_cyc > 0.
   task automatic run_word(input string name, input logic [1:0] wt, input logic [15:0] w,
                           input logic [39:0] pat, input int pulse_cyc);
      int k;
      mil_request   = 1'b1;
      mil_data_type = wt;
      mil_data_word = w;
      tick();
      mil_request = 1'b0;
      check({name, " load"}, outs(), {27'd0, 5'b00001});
      tick();
      for (int cyc = 2; cyc < 2 + 40 * H; cyc++) begin
         k = (cyc - 2) / H;
         if (cyc == pulse_cyc) begin
            mil_request   = 1'b1;
            mil_data_type = ~wt;
            mil_data_word = ~w;
         end else begin
            mil_request = 1'b0;
         end
         check($sformatf("%s hb%0d cyc%0d", name, k, cyc), outs(),
               {27'd0, pat[39 - k], ~pat[39 - k], 3'b101});
         tick();
      end
      mil_request = 1'b0;
      check({name, " done"}, outs(), {27'd0, 5'b00011});
      tick();
      check({name, " idle"}, outs(), {27'd0, 5'b00000});
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      mil_request   = 1'b0;
      mil_data_type = 2'd0;
      mil_data_word = 16'h0000;
      tick();
      tick();
      check("reset", outs(), {27'd0, 5'b00000});

      // Reset wins over a simultaneous request.
      mil_request = 1'b1;
      tick();
      check("rst+req", outs(), {27'd0, 5'b00000});
      rst         = 1'b0;
      mil_request = 1'b0;
      tick();
      check("rst+req after", outs(), {27'd0, 5'b00000});

      run_word("cmd0000", WCOMMAND, 16'h0000, {6'b111000, {16{2'b01}}, 2'b10}, 0);
      tick();
      run_word("dataFFFF", WDATA, 16'hFFFF, {6'b000111, {16{2'b10}}, 2'b10}, 0);
      run_word("err0001", WERROR, 16'h0001, {6'b000111, {15{2'b01}}, 2'b10, 2'b10}, 0);
      run_word("data0001", WDATA, 16'h0001, {6'b000111, {15{2'b01}}, 2'b10, 2'b01}, 0);

      // Back-to-back: next request lands in the first IDLE cycle after done.
      run_word("statA5A5", WSTATUS, 16'hA5A5,
               {6'b111000, {2{16'b1001100101100110}}, 2'b10}, 0);
      run_word("data5A5A", WDATA, 16'h5A5A,
               {6'b000111, {2{16'b0110011010011001}}, 2'b10}, 0);

      // Abort during half-bit 20 (cycles 42..43).
      mil_request   = 1'b1;
      mil_data_type = WDATA;
      mil_data_word = 16'hFFFF;
      tick();
      mil_request = 1'b0;
      for (int i = 1; i < 2 + 20 * H; i++) tick();
      check("abort pre", outs(), {27'd0, 5'b10101});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort now", outs(), {27'd0, 5'b00000});
      for (int i = 0; i < 90; i++) begin
         tick();
         check($sformatf("abort quiet %0d", i), outs(), {27'd0, 5'b00000});
      end
      run_word("cmd8001", WCOMMAND, 16'h8001,
               {6'b111000, 2'b10, {14{2'b01}}, 2'b10, 2'b10}, 0);

      // Stray request at cycle 30 of a word must be ignored.
      run_word("data1234", WDATA, 16'h1234,
               {6'b000111, 32'b01010110_01011001_01011010_01100101, 2'b01}, 30);
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("stray quiet %0d", i), outs(), {27'd0, 5'b00000});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
